ysyx_23060077_div_issue: RTL and testbench
==========================================

# ysyx_23060077_div_issue

Execute-stage initiator for the iterative divider `ysyx_23060077_div`. It accepts RISC-V DIV/DIVU/REM/REMU requests from the EXU over a valid/ready handshake. It resolves the architectural special cases and repeated-operand requests locally, drives the divider's request/flush protocol for everything else, captures the one-cycle divider result pulse, and returns the selected quotient or remainder over a second valid/ready handshake.

## Interface
Parameters:
- `W`, 32, operand and result width.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  pipeline kill; aborts any in-flight operation.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_op`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `req_a` / `req_b`  in  W  dividend and divisor.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  W  result.
- `div_valid`  out  1  request to divider.
- `div_ready`  in  1  divider accepts request.
- `div_signed`  out  1  signed operation.
- `dividend` / `divisor`  out  W  divider operands.
- `div_flush`  out  1  divider abort, one-cycle pulse.
- `div_out_valid`  in  1  single-cycle result pulse; the divider never holds it.
- `quotient` / `remainder`  in  W  divider results, valid only with `div_out_valid`.

## Operation
- States are IDLE, ISSUE, WAIT and RESP. `req_ready` = (state==IDLE).
- **Request accept.** Acceptance occurs on `req_valid & req_ready & ~flush`. The block latches the op, `a`, `b` and `sgn = ~op[0]`, then classifies the request in priority order:
  - **b==0:** go to RESP. Quotient = all ones; remainder = `a`.
  - **Signed overflow** (`sgn`, a==1<<(W-1), b==all ones): go to RESP. Quotient = `a`; remainder = 0.
  - **Cache hit:** cache valid with matching `a`, `b` and `sgn`. Go to RESP with the cached quotient or remainder.
  - **Otherwise:** go to ISSUE.
- **ISSUE.**
  - `div_valid` = 1.
  - `dividend`, `divisor` and `div_signed` are held stable until `div_valid & div_ready`, then the block moves to WAIT.
- **WAIT.**
  - On `div_out_valid`, capture `quotient` and `remainder`.
  - Load the cache with {`a`, `b`, `sgn`, q, r} and set cache valid.
  - Go to RESP with `op[1]` selecting remainder or quotient.
- **RESP.**
  - `rsp_valid` = 1 and `rsp_data` is stable until `rsp_valid & rsp_ready`, then IDLE.
  - A new request is not accepted in the handshake cycle.
- **Flush** is highest priority.
  - From any state, go to IDLE next cycle and drop any pending response.
  - `div_flush` = 1 for exactly one cycle when flush arrives in ISSUE or WAIT; otherwise 0.
  - `div_out_valid` coincident with flush is discarded and the cache is not updated.
  - A request presented together with flush is not accepted.
- **Stray pulses:** `div_out_valid` outside WAIT is ignored.
- **Cache lifetime:** the cache holds one entry. Only `reset` invalidates it; flush does not. Special-case results are never cached.
- **Reset:**
  - State goes to IDLE and cache valid clears.
  - All outputs read 0 in and immediately after reset, including `rsp_valid`, `div_valid`, `div_flush`, `rsp_data` and operands.
  - Reset mid-operation abandons it without asserting `div_flush`; the divider shares `reset`.

## Timing
- All outputs are registered or decoded from registered state; there are no combinational paths from `req_*` or `div_*` inputs to outputs.
- **Fast path** (special case or cache hit): accept at cycle N; `rsp_valid` at N+1.
- **Divider path:**
  - Accept at cycle N; `div_valid` from N+1.
  - Handshake at cycle H gives WAIT from H+1.
  - `div_out_valid` at cycle K gives `rsp_valid` at K+1.
- **Throughput:** one request per (latency + 1) cycles minimum, because of the IDLE turnaround.
- `req_ready` is 1 in the cycle after a response handshake or a flush.

## Structure
- Package `ysyx_23060077_div_pkg` holds:
  - the op encoding constants (DIV/DIVU/REM/REMU);
  - the state enum;
  - default `W`.
- No sub-module: special-case detection, cache compare and result select are small inline logic. The target size is roughly 150–250 lines.

## Test plan
Bench divider model uses 3-cycle latency with a configurable `div_ready` stall. W=32.
- **Divider path, then cache hit:**
  - DIV a=20, b=0xFFFFFFFD: `div_signed`=1, `rsp_data`=0xFFFFFFFA, `rsp_valid` 1 cycle after `div_out_valid`.
  - Then REM with the same operands: `rsp_data`=2 at accept+1, `div_valid` never asserted.
- **Divide by zero:** DIVU 7/0 gives 0xFFFFFFFF; REMU 7/0 gives 7. Both respond at accept+1 with no `div_valid`.
- **Signed overflow:** DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM gives 0. No divider traffic.
- **Backpressure:**
  - `div_ready` low for 5 cycles: `div_valid` and operands held constant.
  - `rsp_ready` low for 3 cycles: `rsp_valid` and `rsp_data` held, `req_ready`=0 throughout.
- **Flush in WAIT:**
  - `div_flush` pulses exactly 1 cycle and `req_ready`=1 the next cycle.
  - The model's late `div_out_valid` produces no `rsp_valid`.
  - A following REM with the same operands goes to the divider, because the cache was not updated.
- **Reset:**
  - Reset during ISSUE: all outputs 0 the next cycle and `div_flush` stays 0.
  - A repeat of a previously cached operand pair goes to the divider.

Source files
------------

// File: rtl/ysyx_23060077_div_issue_pkg.sv
// Shared definitions for the divider issue block: op encoding, FSM states, default width.
package ysyx_23060077_div_pkg;

    localparam int W_DEF = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/ysyx_23060077_div_issue_if.sv
// Request, response and divider-side handshake bundle of the divider issue block.
interface ysyx_23060077_div_issue_if #(
    parameter int W = ysyx_23060077_div_pkg::W_DEF
);
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;

    logic         div_valid;
    logic         div_ready;
    logic         div_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         div_flush;
    logic         div_out_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        input  div_ready, div_out_valid, quotient, remainder,
        output req_ready, rsp_valid, rsp_data,
        output div_valid, div_signed, dividend, divisor, div_flush
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        output div_ready, div_out_valid, quotient, remainder,
        input  req_ready, rsp_valid, rsp_data,
        input  div_valid, div_signed, dividend, divisor, div_flush
    );
endinterface

// File: rtl/ysyx_23060077_div_issue.sv
// Execute-stage initiator for the iterative divider: resolves special cases and
// repeated operands locally, otherwise issues to the divider and returns q or r.
module ysyx_23060077_div_issue
    import ysyx_23060077_div_pkg::*;
#(
    parameter int W = W_DEF
) (
    input logic                  clock,
    input logic                  reset,
    input logic                  flush,
    ysyx_23060077_div_issue_if.slave bus
);

    state_t       state;
    logic [1:0]   op_q;

    logic         rsp_valid_q;
    logic [W-1:0] rsp_data_q;
    logic         div_valid_q;
    logic         div_signed_q;
    logic [W-1:0] dividend_q;
    logic [W-1:0] divisor_q;
    logic         div_flush_q;

    logic         cache_valid;
    logic [W-1:0] cache_a;
    logic [W-1:0] cache_b;
    logic         cache_sgn;
    logic [W-1:0] cache_q;
    logic [W-1:0] cache_r;

    logic         sgn_in;
    logic         rem_in;
    logic         b_zero;
    logic         overflow;
    logic         hit;
    logic         fast;
    logic [W-1:0] fast_data;

    assign sgn_in   = op_is_signed(bus.req_op);
    assign rem_in   = op_is_rem(bus.req_op);
    assign b_zero   = (bus.req_b == '0);
    assign overflow = sgn_in && (bus.req_a == {1'b1, {(W-1){1'b0}}}) && (&bus.req_b);
    assign hit      = cache_valid && (cache_a == bus.req_a) && (cache_b == bus.req_b)
                      && (cache_sgn == sgn_in);
    assign fast     = b_zero || overflow || hit;

    // Priority order matters: divide-by-zero before overflow before the cache.
    always_comb begin
        fast_data = '0;
        if (b_zero)
            fast_data = rem_in ? bus.req_a : '1;
        else if (overflow)
            fast_data = rem_in ? '0 : bus.req_a;
        else if (hit)
            fast_data = rem_in ? cache_r : cache_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            op_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            div_valid_q  <= 1'b0;
            div_signed_q <= 1'b0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            div_flush_q  <= 1'b0;
            cache_valid  <= 1'b0;
            cache_a      <= '0;
            cache_b      <= '0;
            cache_sgn    <= 1'b0;
            cache_q      <= '0;
            cache_r      <= '0;
        end else if (flush) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            div_valid_q <= 1'b0;
            div_flush_q <= (state == ST_ISSUE) || (state == ST_WAIT);
        end else begin
            div_flush_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q <= bus.req_op;
                        if (fast) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= fast_data;
                            state       <= ST_RESP;
                        end else begin
                            div_valid_q  <= 1'b1;
                            div_signed_q <= sgn_in;
                            dividend_q   <= bus.req_a;
                            divisor_q    <= bus.req_b;
                            state        <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.div_ready) begin
                        div_valid_q <= 1'b0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Operand registers still hold this request, so they key the cache.
                    if (bus.div_out_valid) begin
                        cache_valid <= 1'b1;
                        cache_a     <= dividend_q;
                        cache_b     <= divisor_q;
                        cache_sgn   <= div_signed_q;
                        cache_q     <= bus.quotient;
                        cache_r     <= bus.remainder;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= op_is_rem(op_q) ? bus.remainder : bus.quotient;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.div_valid  = div_valid_q;
    assign bus.div_signed = div_signed_q;
    assign bus.dividend   = dividend_q;
    assign bus.divisor    = divisor_q;
    assign bus.div_flush  = div_flush_q;

endmodule

// File: tb/tb_ysyx_23060077_div_issue.sv
// Directed bench for the divider issue block with a 3-cycle divider model.
module tb_ysyx_23060077_div_issue;

    logic clock = 1'b0;
    logic reset;
    logic flush;

    int checks     = 0;
    int failures   = 0;
    int dv_cycles  = 0;
    int dv_mark    = 0;
    int model_cnt  = 0;

    ysyx_23060077_div_issue_if #(.W(32)) bus ();

    ysyx_23060077_div_issue #(.W(32)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset && bus.div_valid)
            dv_cycles <= dv_cycles + 1;
    end

    // Divider model: result pulse sampled by the DUT three edges after the handshake.
    always @(posedge clock) begin
        if (reset) begin
            model_cnt         <= 0;
            bus.div_out_valid <= 1'b0;
            bus.quotient      <= '0;
            bus.remainder     <= '0;
        end else begin
            bus.div_out_valid <= (model_cnt == 1);
            if (model_cnt > 0)
                model_cnt <= model_cnt - 1;
            if (bus.div_valid && bus.div_ready) begin
                model_cnt <= 2;
                if (bus.div_signed) begin
                    bus.quotient  <= $signed(bus.dividend) / $signed(bus.divisor);
                    bus.remainder <= $signed(bus.dividend) % $signed(bus.divisor);
                end else begin
                    bus.quotient  <= bus.dividend / bus.divisor;
                    bus.remainder <= bus.dividend % bus.divisor;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        for (int i = 0; i < 20 && !bus.req_ready; i++) tick();
        chk("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic take();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("rsp_dropped", {31'b0, bus.rsp_valid}, 32'd0);
        chk("ready_after_rsp", {31'b0, bus.req_ready}, 32'd1);
    endtask

    task automatic wait_out();
        for (int i = 0; i < 20 && !bus.div_out_valid; i++) tick();
        chk("div_out_timeout", {31'b0, bus.div_out_valid}, 32'd1);
        tick();
        chk("rsp_after_out", {31'b0, bus.rsp_valid}, 32'd1);
    endtask

    task automatic fast_rsp(input string tag, input logic [31:0] exp);
        chk({tag, "_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
        chk({tag, "_data"}, bus.rsp_data, exp);
        chk({tag, "_no_div"}, {31'b0, bus.div_valid}, 32'd0);
        take();
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        bus.div_ready = 1'b1;
        tick(); tick(); tick();
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_div_valid", {31'b0, bus.div_valid}, 32'd0);
        chk("rst_div_flush", {31'b0, bus.div_flush}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_dividend", bus.dividend, 32'd0);
        reset = 1'b0;
        tick();

        // DIV 20 / -3 through the divider
        send(2'b00, 32'd20, 32'hFFFF_FFFD);
        chk("div1_valid", {31'b0, bus.div_valid}, 32'd1);
        chk("div1_signed", {31'b0, bus.div_signed}, 32'd1);
        chk("div1_dividend", bus.dividend, 32'd20);
        chk("div1_divisor", bus.divisor, 32'hFFFF_FFFD);
        wait_out();
        chk("div1_data", bus.rsp_data, 32'hFFFF_FFFA);
        take();

        // REM with same operands hits the cache
        dv_mark = dv_cycles;
        send(2'b10, 32'd20, 32'hFFFF_FFFD);
        fast_rsp("hit_rem", 32'd2);

        send(2'b01, 32'd7, 32'd0);
        fast_rsp("divu_zero", 32'hFFFF_FFFF);
        send(2'b11, 32'd7, 32'd0);
        fast_rsp("remu_zero", 32'd7);

        send(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        fast_rsp("ovf_div", 32'h8000_0000);
        send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        fast_rsp("ovf_rem", 32'd0);
        chk("fast_no_div_traffic", dv_cycles, dv_mark);

        // Divider and response backpressure: DIVU 100/7
        bus.div_ready = 1'b0;
        send(2'b01, 32'd100, 32'd7);
        for (int i = 0; i < 5; i++) begin
            chk("stall_div_valid", {31'b0, bus.div_valid}, 32'd1);
            chk("stall_dividend", bus.dividend, 32'd100);
            chk("stall_divisor", bus.divisor, 32'd7);
            chk("stall_signed", {31'b0, bus.div_signed}, 32'd0);
            tick();
        end
        bus.div_ready = 1'b1;
        tick();
        chk("hs_div_valid_low", {31'b0, bus.div_valid}, 32'd0);
        wait_out();
        for (int i = 0; i < 3; i++) begin
            chk("bp_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            chk("bp_rsp_data", bus.rsp_data, 32'd14);
            chk("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
            tick();
        end
        take();

        // Flush in WAIT: DIV 1000 / -7
        send(2'b00, 32'd1000, 32'hFFFF_FFF9);
        tick();
        chk("fl_in_wait", {31'b0, bus.div_valid}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_div_flush", {31'b0, bus.div_flush}, 32'd1);
        chk("fl_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("fl_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        tick();
        chk("fl_pulse_end", {31'b0, bus.div_flush}, 32'd0);
        tick();
        tick();
        chk("fl_stray_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        chk("fl_idle", {31'b0, bus.req_ready}, 32'd1);

        send(2'b10, 32'd1000, 32'hFFFF_FFF9);
        chk("fl_rem_miss", {31'b0, bus.div_valid}, 32'd1);
        wait_out();
        chk("fl_rem_data", bus.rsp_data, 32'd6);
        take();

        // Reset during ISSUE
        bus.div_ready = 1'b0;
        send(2'b01, 32'd9, 32'd2);
        chk("rs_issue", {31'b0, bus.div_valid}, 32'd1);
        reset = 1'b1;
        tick();
        chk("rs_div_valid", {31'b0, bus.div_valid}, 32'd0);
        chk("rs_div_flush", {31'b0, bus.div_flush}, 32'd0);
        chk("rs_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rs_rsp_data", bus.rsp_data, 32'd0);
        chk("rs_dividend", bus.dividend, 32'd0);
        chk("rs_divisor", bus.divisor, 32'd0);
        chk("rs_signed", {31'b0, bus.div_signed}, 32'd0);
        reset = 1'b0;
        tick();
        chk("rs_flush_quiet", {31'b0, bus.div_flush}, 32'd0);
        bus.div_ready = 1'b1;

        send(2'b10, 32'd1000, 32'hFFFF_FFF9);
        chk("rs_cache_cleared", {31'b0, bus.div_valid}, 32'd1);
        wait_out();
        chk("rs_rem_data", bus.rsp_data, 32'd6);
        take();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
